// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: column-scanning keypad reader with press/release debounce,
// linear key encoding, valid/ack delivery, multi-key detection and sticky overrun.
module matrix_key_scanner #(
    parameter int NUM_ROWS        = 4,
    parameter int NUM_COLS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CODE_W         = $clog2(NUM_ROWS * NUM_COLS)
) (
    input  logic                newClock,
    input  logic                resetN,
    input  logic [NUM_ROWS-1:0] ROW,
    output logic [NUM_COLS-1:0] COL,
    output logic [CODE_W-1:0]   keyCode,
    output logic                keyValid,
    input  logic                keyAck,
    output logic                keyHeld,
    output logic                multiKey,
    output logic                overrun
);
    localparam int CW  = $clog2(NUM_COLS);
    localparam int RW  = $clog2(NUM_ROWS);
    localparam int CNW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d, col_nx;
    logic [CNW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [NUM_ROWS-1:0] pat_q, pat_d, low;
    logic [CODE_W-1:0]   code_q, code_d, code;
    logic                valid_q, valid_d, held_q, held_d, multi_q, multi_d, ovr_q, ovr_d;
    logic                done, multi, emit;
    logic [RW-1:0]       row_idx;

    assign col_nx  = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + CW'(1);
    assign cnt_inc = cnt_q + CNW'(1);
    assign done    = cnt_inc == CNW'(DEBOUNCE_CYCLES);
    assign low     = ~pat_q;
    // More than one bit set in the low-row mask means several rows pressed.
    assign multi   = |(low & (low - NUM_ROWS'(1)));
    assign code    = CODE_W'(int'(row_idx) * NUM_COLS + int'(col_q));

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < NUM_ROWS; i++)
            if (!pat_q[i]) row_idx = RW'(i);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        code_d  = code_q;
        valid_d = valid_q;
        held_d  = held_q;
        multi_d = 1'b0;
        ovr_d   = ovr_q;
        emit    = 1'b0;
        case (state_q)
            SCAN:
                if (&ROW) col_d = col_nx;
                else begin
                    pat_d   = ROW;
                    cnt_d   = CNW'(1);
                    state_d = DEBOUNCE;
                end
            DEBOUNCE:
                if (ROW != pat_q) state_d = SCAN;
                else begin
                    cnt_d = cnt_inc;
                    if (done) begin
                        state_d = HELD;
                        held_d  = 1'b1;
                        multi_d = multi;
                        emit    = !multi;
                    end
                end
            HELD:
                if (&ROW) begin
                    cnt_d   = CNW'(1);
                    state_d = RELEASE;
                end
            RELEASE:
                if (!(&ROW)) state_d = HELD;
                else begin
                    cnt_d = cnt_inc;
                    if (done) begin
                        state_d = SCAN;
                        held_d  = 1'b0;
                        col_d   = col_nx;
                    end
                end
            default: state_d = SCAN;
        endcase
        // An ack in the emit cycle frees the slot for the new code.
        if (emit && (!valid_q || keyAck)) begin
            code_d  = code;
            valid_d = 1'b1;
        end else if (emit) ovr_d = 1'b1;
        else if (valid_q && keyAck) valid_d = 1'b0;
    end

    always_ff @(posedge newClock or negedge resetN) begin
        if (!resetN) begin
            state_q <= SCAN;
            col_q   <= '0;
            cnt_q   <= '0;
            pat_q   <= '1;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            multi_q <= multi_d;
            ovr_q   <= ovr_d;
        end
    end

    assign COL      = ~(NUM_COLS'(1) << col_q);
    assign keyCode  = code_q;
    assign keyValid = valid_q;
    assign keyHeld  = held_q;
    assign multiKey = multi_q;
    assign overrun  = ovr_q;
endmodule

// File: tb/tb_matrix_key_scanner.sv
// tb_matrix_key_scanner: 4x4 keypad model driving the scanner; expected key
// codes are queued at press time and checked when the scanner commits.
module tb_matrix_key_scanner;
    logic        newClock = 1'b0;
    logic        resetN   = 1'b0;
    logic [3:0]  ROW, COL;
    logic [3:0]  keyCode;
    logic        keyValid, keyAck = 1'b0, keyHeld, multiKey, overrun;
    logic [15:0] keys = '0;
    logic [3:0]  sb[$];
    logic [3:0]  exp_code, exp_col;
    int          checks = 0, errors = 0;

    always #5 newClock = ~newClock;

    matrix_key_scanner #(.NUM_ROWS(4), .NUM_COLS(4), .DEBOUNCE_CYCLES(4)) dut (
        .newClock(newClock), .resetN(resetN), .ROW(ROW), .COL(COL),
        .keyCode(keyCode), .keyValid(keyValid), .keyAck(keyAck),
        .keyHeld(keyHeld), .multiKey(multiKey), .overrun(overrun)
    );

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        ROW = '1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
    end

    task automatic step();
        @(posedge newClock);
        #1;
    endtask

    task automatic wait_col(input int c);
        logic [3:0] want;
        bit found = 0;
        want = ~(4'b0001 << c);
        for (int i = 0; i < 8 && !found; i++) begin
            if (COL === want) found = 1;
            else step();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_col: COL=%b never reached %b", COL, want);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (COL !== 4'b1110 || keyValid !== 1'b0 || keyHeld !== 1'b0 || multiKey !== 1'b0 ||
            overrun !== 1'b0 || keyCode !== 4'd0) begin
            errors++;
            $display("FAIL %s: COL=%b valid=%b held=%b multi=%b ovr=%b code=%0d, want 1110 0 0 0 0 0",
                     tag, COL, keyValid, keyHeld, multiKey, overrun, keyCode);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        #1;
        check_reset_outputs("reset_state");
        @(negedge newClock) resetN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_col = ~(4'b0001 << ((i + 1) % 4));
            checks++;
            if (COL !== exp_col || keyValid !== 1'b0 || keyHeld !== 1'b0 || overrun !== 1'b0) begin
                errors++;
                $display("FAIL idle_scan[%0d]: COL=%b valid=%b held=%b ovr=%b, want COL=%b 0 0 0",
                         i, COL, keyValid, keyHeld, overrun, exp_col);
            end
        end
    endtask

    task automatic test_clean_press();
        wait_col(1);
        keys[9] = 1'b1;
        sb.push_back(4'd9);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (keyValid !== 1'b0 || keyHeld !== 1'b0 || COL !== 4'b1101) begin
                errors++;
                $display("FAIL press_debounce[%0d]: valid=%b held=%b COL=%b, want 0 0 1101",
                         i, keyValid, keyHeld, COL);
            end
        end
        step();
        checks++;
        if (keyValid !== 1'b1 || keyHeld !== 1'b1) begin
            errors++;
            $display("FAIL press_commit: valid=%b held=%b, want 1 1", keyValid, keyHeld);
        end
        exp_code = (sb.size() != 0) ? sb.pop_front() : 4'hx;
        checks++;
        if (keyCode !== exp_code) begin
            errors++;
            $display("FAIL press_code: keyCode=%0d, want %0d", keyCode, exp_code);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (keyValid !== 1'b1 || keyCode !== 4'd9) begin
                errors++;
                $display("FAIL press_wait_ack[%0d]: valid=%b code=%0d, want 1 9", i, keyValid, keyCode);
            end
        end
        keyAck = 1'b1;
        step();
        keyAck = 1'b0;
        checks++;
        if (keyValid !== 1'b0) begin
            errors++;
            $display("FAIL ack_edge: valid=%b, want 0", keyValid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (keyHeld !== 1'b1 || COL !== 4'b1101 || keyValid !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: held=%b COL=%b valid=%b, want 1 1101 0", i, keyHeld, COL, keyValid);
            end
        end
        keys = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (keyHeld !== 1'b1 || COL !== 4'b1101) begin
                errors++;
                $display("FAIL release_debounce[%0d]: held=%b COL=%b, want 1 1101", i, keyHeld, COL);
            end
        end
        step();
        checks++;
        if (keyHeld !== 1'b0 || COL !== 4'b1011) begin
            errors++;
            $display("FAIL release_done: held=%b COL=%b, want 0 1011", keyHeld, COL);
        end
    endtask

    task automatic test_bounce();
        wait_col(3);
        keys[3] = 1'b1;
        step();
        step();
        keys = '0;
        step();
        checks++;
        if (COL !== 4'b0111 || keyValid !== 1'b0 || keyHeld !== 1'b0) begin
            errors++;
            $display("FAIL bounce_abort: COL=%b valid=%b held=%b, want 0111 0 0", COL, keyValid, keyHeld);
        end
        step();
        checks++;
        if (COL !== 4'b1110 || keyValid !== 1'b0 || keyHeld !== 1'b0) begin
            errors++;
            $display("FAIL bounce_rescan: COL=%b valid=%b held=%b, want 1110 0 0", COL, keyValid, keyHeld);
        end
        step();
        checks++;
        if (COL !== 4'b1101) begin
            errors++;
            $display("FAIL bounce_rotate: COL=%b, want 1101", COL);
        end
    endtask

    task automatic test_multikey();
        wait_col(2);
        keys[2]  = 1'b1;
        keys[14] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (multiKey !== 1'b0) begin
                errors++;
                $display("FAIL multi_early[%0d]: multiKey=%b, want 0", i, multiKey);
            end
        end
        step();
        checks++;
        if (multiKey !== 1'b1 || keyHeld !== 1'b1 || keyValid !== 1'b0) begin
            errors++;
            $display("FAIL multi_commit: multi=%b held=%b valid=%b, want 1 1 0", multiKey, keyHeld, keyValid);
        end
        step();
        checks++;
        if (multiKey !== 1'b0 || keyHeld !== 1'b1 || keyValid !== 1'b0) begin
            errors++;
            $display("FAIL multi_pulse_end: multi=%b held=%b valid=%b, want 0 1 0", multiKey, keyHeld, keyValid);
        end
        keys = '0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (keyHeld !== 1'b1) begin
            errors++;
            $display("FAIL multi_release_early: held=%b, want 1", keyHeld);
        end
        step();
        checks++;
        if (keyHeld !== 1'b0 || COL !== 4'b0111 || keyValid !== 1'b0) begin
            errors++;
            $display("FAIL multi_release: held=%b COL=%b valid=%b, want 0 0111 0", keyHeld, COL, keyValid);
        end
    endtask

    task automatic test_overrun();
        int         rr[3]   = '{1, 3, 0};
        int         cc[3]   = '{1, 2, 0};
        logic       ak[3]   = '{1'b0, 1'b0, 1'b1};
        logic [3:0] ec[3]   = '{4'd5, 4'd5, 4'd0};
        logic       eo[3]   = '{1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 3; k++) begin
            wait_col(cc[k]);
            keys[rr[k]*4+cc[k]] = 1'b1;
            sb.push_back(ec[k]);
            for (int i = 0; i < 3; i++) step();
            keyAck = ak[k];
            step();
            keyAck = 1'b0;
            exp_code = (sb.size() != 0) ? sb.pop_front() : 4'hx;
            checks++;
            if (keyValid !== 1'b1 || keyCode !== exp_code || overrun !== eo[k] || keyHeld !== 1'b1) begin
                errors++;
                $display("FAIL overrun_key%0d: valid=%b code=%0d ovr=%b held=%b, want 1 %0d %b 1",
                         k, keyValid, keyCode, overrun, keyHeld, exp_code, eo[k]);
            end
            keys = '0;
            for (int i = 0; i < 4; i++) step();
            checks++;
            if (keyHeld !== 1'b0 || keyCode !== exp_code) begin
                errors++;
                $display("FAIL overrun_release%0d: held=%b code=%0d, want 0 %0d", k, keyHeld, keyCode, exp_code);
            end
        end
    endtask

    task automatic test_async_reset();
        wait_col(1);
        keys[9] = 1'b1;
        step();
        step();
        #2 resetN = 1'b0;
        #1;
        check_reset_outputs("reset_in_debounce");
        keys = '0;
        @(negedge newClock) resetN = 1'b1;
        step();
        checks++;
        if (COL !== 4'b1101) begin
            errors++;
            $display("FAIL resume_after_reset1: COL=%b, want 1101", COL);
        end
        wait_col(2);
        keys[10] = 1'b1;
        sb.push_back(4'd10);
        for (int i = 0; i < 4; i++) step();
        exp_code = (sb.size() != 0) ? sb.pop_front() : 4'hx;
        checks++;
        if (keyValid !== 1'b1 || keyCode !== exp_code) begin
            errors++;
            $display("FAIL pre_reset_commit: valid=%b code=%0d, want 1 %0d", keyValid, keyCode, exp_code);
        end
        #2 resetN = 1'b0;
        #1;
        check_reset_outputs("reset_with_valid");
        keys = '0;
        @(negedge newClock) resetN = 1'b1;
        step();
        checks++;
        if (COL !== 4'b1101) begin
            errors++;
            $display("FAIL resume_after_reset2: COL=%b, want 1101", COL);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multikey();
        test_overrun();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/matrix_key_scanner.md
# matrix_key_scanner

Parametrised matrix keypad scanner for any NUM_ROWS x NUM_COLS keypad, running on the 500 Hz scan clock. It drives one active-low column at a time, debounces press and release, and encodes the key as a linear code. Each key is delivered once through a valid/ack handshake to the downstream decoder/display logic. It adds multi-key detection and overrun flagging.

## Interface
- NUM_ROWS, 4, number of row inputs (>=2)
- NUM_COLS, 4, number of column outputs (>=2)
- DEBOUNCE_CYCLES, 4, consecutive identical samples required to accept a press or release (>=2)
- CODE_W (localparam), clog2(NUM_ROWS*NUM_COLS), keyCode width
- newClock  in  1  scan clock, all logic on rising edge
- resetN  in  1  asynchronous active-low reset
- ROW  in  NUM_ROWS  row lines, active-low; already synchronised to newClock upstream
- COL  out  NUM_COLS  column drive, exactly one bit low
- keyCode  out  CODE_W  rowIdx*NUM_COLS + colIdx of last accepted key
- keyValid  out  1  keyCode holds an unacknowledged key
- keyAck  in  1  consumer acknowledge, sampled only while keyValid=1
- keyHeld  out  1  a debounced key is currently down
- multiKey  out  1  one-cycle pulse: debounced press had >1 row low
- overrun  out  1  sticky: key accepted while keyValid=1 was dropped

## Operation
- colIdx register, COL = ~(1 << colIdx). States: SCAN, DEBOUNCE, HELD, RELEASE.
- Reset values: state SCAN, colIdx 0 (COL = all ones with bit0 low), counter 0, keyCode 0, keyValid 0, keyHeld 0, multiKey 0, overrun 0.
- SCAN: ROW all high -> colIdx increments, wrapping NUM_COLS-1 -> 0. Any row low -> capture row pattern, counter=1, go DEBOUNCE, colIdx frozen.
- DEBOUNCE: ROW equals captured pattern -> counter++. Counter reaches DEBOUNCE_CYCLES -> commit, go HELD, keyHeld=1. ROW differs -> go SCAN with colIdx unchanged, no output.
- Commit with exactly one row low: code = lowRowIdx*NUM_COLS + colIdx. Commit with >1 row low: multiKey pulses, no code emitted.
- Emit when keyValid=0 -> keyCode=code, keyValid=1.
- Emit when keyValid=1 with keyAck=1 the same cycle -> keyCode=code, keyValid stays 1, no overrun.
- Emit when keyValid=1, keyAck=0 -> code dropped, keyCode unchanged, overrun=1 (cleared only by reset).
- Handshake: keyValid=1 and keyAck=1 at an edge with no emit -> keyValid=0. keyAck while keyValid=0 ignored. keyCode stable while keyValid=1.
- HELD: colIdx frozen. ROW all high -> counter=1, go RELEASE.
- RELEASE: ROW all high -> counter++. Counter reaches DEBOUNCE_CYCLES -> go SCAN, keyHeld=0, colIdx increments. Any row low -> back to HELD.
- Press in another column while HELD is not seen: that column is not driven.

## Timing
- One COL step per edge in SCAN; full sweep NUM_COLS cycles.
- Press sampled at edge t0 (capture). keyValid/keyCode/keyHeld registered at edge t0+DEBOUNCE_CYCLES-1 if samples t0..t0+D-1 all match. multiKey is high for exactly that one cycle.
- First all-high sample in HELD at edge r0. keyHeld falls and COL rotates at edge r0+D-1.
- Ack latency: keyValid falls on the edge that samples keyAck=1.
- resetN low forces all reset values immediately, in any state, mid-debounce or mid-handshake. Scanning resumes at column 0 on the first edge after release.

## Test plan
- Reset, ROW=4'b1111 for 8 cycles -> COL 1110,1101,1011,0111,1110,... keyValid/keyHeld/overrun 0.
- Clean press at row2/col1, hold 10 cycles, ack after 2 cycles, release (D=4) -> keyCode=9, keyValid high 3 edges after capture. keyValid low on ack edge. keyHeld low 3 edges after first high sample. Next COL=1011.
- Bounce: row0 low 2 samples then high at col3 -> no keyValid/keyHeld; SCAN re-samples col3 next edge, then continues rotating.
- Rows 0 and 3 low at col2, held -> multiKey single-cycle pulse at commit, keyValid stays 0, keyHeld 1 until debounced release.
- Key 5 then key 14 without ack -> keyCode stays 5, overrun=1. Ack coincident with third commit (key 0) -> keyCode=0, keyValid 1, overrun remains 1.
- resetN pulsed low in DEBOUNCE and again with keyValid=1 -> all outputs at reset values asynchronously, COL=1110.
